core_mem_arbiter: RTL and testbench
===================================

Name: core_mem_arbiter

Overview:
Shares one backing-memory port between the core's instruction-fetch port and data-memory port. Sits between the core's instr_cache_*/data_cache_* interface and a single word-addressed memory with an ack handshake. Drives the core's blocking_n stall inputs. Arbitration is fixed data-priority with a starvation limiter for fetch.

Parameters:
STARVE_LIMIT, 4, max consecutive data grants while a fetch is pending before fetch is forced next (1..15)
TIMEOUT_CYCLES, 64, ack wait limit when CORE_MEM_ARB_TIMEOUT_EN is defined

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous reset, active-high
instr_req_i  in  1  fetch request, level, held until completion
instr_addr_i  in  30  fetch word address [31:2]
instr_data_o  out  32  fetch read data
instr_blocking_n_o  out  1  0 = fetch stalled
data_req_i  in  1  data request (core data_cache_enabled_o), level
data_addr_i  in  30  data word address [31:2]
data_write_en_i  in  4  byte write enables; 0 = load
data_wdata_i  in  32  store data
data_rdata_o  out  32  load data
data_blocking_n_o  out  1  0 = data access stalled
mem_req_o  out  1  memory request
mem_addr_o  out  30  memory word address
mem_we_o  out  4  memory byte enables
mem_wdata_o  out  32  memory write data
mem_rdata_i  in  32  memory read data, valid with mem_ack_i
mem_ack_i  in  1  memory completion, 1-cycle pulse
mem_err_o  out  1  timeout error pulse (0 without macro)

Behaviour:
- Reset (async, immediate): state IDLE; mem_req_o=0, mem_addr_o=0, mem_we_o=0, mem_wdata_o=0; instr_data_o=0, data_rdata_o=0; starve counter=0; mem_err_o=0; both blocking_n_o=1 while rst_i high.
- FSM states: IDLE, GRANT_I, GRANT_D, DONE_I, DONE_D.
- IDLE: if data_req_i and not (instr_req_i and starve==STARVE_LIMIT) -> GRANT_D. Else if instr_req_i -> GRANT_I. Else stay. The winner's addr/we/wdata are latched into mem_*_o registers on this edge. Fetch we is always 0.
- GRANT_x: mem_req_o=1, address/we/wdata held stable. On mem_ack_i: latch mem_rdata_i into the winner's data output (loads and fetches only; stores leave data_rdata_o unchanged); mem_req_o drops next cycle; -> DONE_x.
- DONE_x: the winner's blocking_n_o=1 for exactly this cycle, with the data output valid; -> IDLE. The requester drops or changes its request on the next edge.
- blocking_n_o (combinational): port blocking_n_o = ~req_i | (state==DONE_port). A new request stalls in its first cycle.
- Latency: minimum 2 stall cycles (ack in the first GRANT cycle). Back-to-back grants have 1 IDLE bubble. Data outputs hold until the next completion on the same port.
- Starve counter: +1 (saturating at STARVE_LIMIT) on each GRANT_D entry while instr_req_i=1. Cleared on GRANT_I entry or when instr_req_i=0 in IDLE.
- Simultaneous requests in IDLE: data wins unless the counter has reached STARVE_LIMIT.
- A request deasserted while granted is ignored. The transaction completes and the DONE pulse is still produced.
- mem_ack_i outside GRANT_x is ignored.

Optional Feature:
CORE_MEM_ARB_TIMEOUT_EN
- Defined: a cycle counter runs in GRANT_x. If TIMEOUT_CYCLES elapse with no ack, go to DONE_x with the read output set to 32'hdeadbeef, pulse mem_err_o for 1 cycle and drop mem_req_o.
- Undefined: GRANT_x waits indefinitely, and mem_err_o is tied 0.

Test Plan:
- Reset with data_req_i=1 -> mem_req_o=0, both blocking_n_o=1. After release: data_blocking_n_o=0 the same cycle, then GRANT_D.
- Fetch addr 0x0000_0010>>2, ack in the first GRANT cycle with rdata 0x00500093 -> instr_blocking_n_o high exactly 2 cycles after the request, instr_data_o=0x00500093.
- Store: we=4'b0011, wdata=0xA5A5_1234, addr 0x100>>2 -> mem_we_o=0011, mem_wdata_o matches, data_rdata_o unchanged after ack.
- Fetch and data held high continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
- Ack delayed 5 cycles -> mem_req_o/addr stable for 5 cycles, single DONE pulse, no grant to the other port before IDLE.
- Macro defined, TIMEOUT_CYCLES=8, no ack -> mem_err_o pulses after 8 cycles, data_rdata_o=0xdeadbeef, data_blocking_n_o=1 for one cycle.

Source files
------------

// File: rtl/core_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_arbiter_if
// Description : Core fetch/data ports and shared memory port bundle used by
//               core_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface core_mem_arbiter_if;
  logic        instr_req_i;
  logic [29:0] instr_addr_i;
  logic [31:0] instr_data_o;
  logic        instr_blocking_n_o;
  logic        data_req_i;
  logic [29:0] data_addr_i;
  logic [3:0]  data_write_en_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        data_blocking_n_o;
  logic        mem_req_o;
  logic [29:0] mem_addr_o;
  logic [3:0]  mem_we_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        mem_err_o;

  modport slave (
    input  instr_req_i, instr_addr_i, data_req_i, data_addr_i, data_write_en_i,
           data_wdata_i, mem_rdata_i, mem_ack_i,
    output instr_data_o, instr_blocking_n_o, data_rdata_o, data_blocking_n_o,
           mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_err_o
  );

  modport master (
    output instr_req_i, instr_addr_i, data_req_i, data_addr_i, data_write_en_i,
           data_wdata_i, mem_rdata_i, mem_ack_i,
    input  instr_data_o, instr_blocking_n_o, data_rdata_o, data_blocking_n_o,
           mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o, mem_err_o
  );
endinterface
`default_nettype wire

// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : core_mem_arbiter
// Description : Shares one memory port between core fetch and data ports;
//               data-priority with a fetch starvation limiter. Optional ack
//               timeout enabled by macro CORE_MEM_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module core_mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  core_mem_arbiter_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_GRANT_I = 3'd1;
  localparam logic [2:0] S_GRANT_D = 3'd2;
  localparam logic [2:0] S_DONE_I  = 3'd3;
  localparam logic [2:0] S_DONE_D  = 3'd4;

  localparam logic [3:0]  c_STARVE_MAX = 4'(STARVE_LIMIT);
  localparam logic [31:0] c_ERR_DATA   = 32'hdeadbeef;

  logic [2:0]  r_state;
  logic [2:0]  w_next;
  logic [3:0]  r_starve;
  logic        r_mem_req;
  logic [29:0] r_mem_addr;
  logic [3:0]  r_mem_we;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_instr_data;
  logic [31:0] r_data_rdata;
  logic        w_in_grant;
  logic        w_data_wins;
  logic        w_timeout;
  logic        w_done;
  logic        w_instr_blk_n;
  logic        w_data_blk_n;

  assign w_in_grant  = (r_state == S_GRANT_I) || (r_state == S_GRANT_D);
  assign w_data_wins = bus.data_req_i && !(bus.instr_req_i && (r_starve == c_STARVE_MAX));
  assign w_done      = w_in_grant && (bus.mem_ack_i || w_timeout);

`ifdef CORE_MEM_ARB_TIMEOUT_EN
  localparam int              c_TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_TW-1:0] c_TLAST = c_TW'(TIMEOUT_CYCLES - 1);

  logic [c_TW-1:0] r_tcnt;
  logic            r_mem_err;

  // Counter sits at zero outside GRANT so each grant gets the full window.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tcnt    <= '0;
      r_mem_err <= 1'b0;
    end else begin
      r_mem_err <= w_in_grant && w_timeout;
      if (w_in_grant && !w_done) r_tcnt <= r_tcnt + 1'b1;
      else                       r_tcnt <= '0;
    end
  end

  assign w_timeout   = (r_tcnt == c_TLAST) && !bus.mem_ack_i;
  assign bus.mem_err_o = r_mem_err;
`else
  logic [31:0] w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign w_timeout     = 1'b0;
  assign bus.mem_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_data_wins)          w_next = S_GRANT_D;
        else if (bus.instr_req_i) w_next = S_GRANT_I;
      end
      S_GRANT_I: if (w_done) w_next = S_DONE_I;
      S_GRANT_D: if (w_done) w_next = S_DONE_D;
      S_DONE_I:  w_next = S_IDLE;
      S_DONE_D:  w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Stall is released only in the port's DONE cycle; reset forces both open.
  always_comb begin
    w_instr_blk_n = !bus.instr_req_i || (r_state == S_DONE_I);
    w_data_blk_n  = !bus.data_req_i  || (r_state == S_DONE_D);
    if (rst_i) begin
      w_instr_blk_n = 1'b1;
      w_data_blk_n  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_starve     <= '0;
      r_mem_req    <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_we     <= '0;
      r_mem_wdata  <= '0;
      r_instr_data <= '0;
      r_data_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!bus.instr_req_i || (w_next == S_GRANT_I))
            r_starve <= '0;
          else if ((w_next == S_GRANT_D) && (r_starve != c_STARVE_MAX))
            r_starve <= r_starve + 4'd1;
          if (w_next == S_GRANT_D) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= bus.data_addr_i;
            r_mem_we    <= bus.data_write_en_i;
            r_mem_wdata <= bus.data_wdata_i;
          end else if (w_next == S_GRANT_I) begin
            r_mem_req   <= 1'b1;
            r_mem_addr  <= bus.instr_addr_i;
            r_mem_we    <= 4'b0000;
            r_mem_wdata <= 32'h0;
          end
        end
        S_GRANT_I: begin
          if (w_done) begin
            r_mem_req    <= 1'b0;
            r_instr_data <= w_timeout ? c_ERR_DATA : bus.mem_rdata_i;
          end
        end
        S_GRANT_D: begin
          if (w_done) begin
            r_mem_req <= 1'b0;
            if (w_timeout)             r_data_rdata <= c_ERR_DATA;
            else if (r_mem_we == 4'b0) r_data_rdata <= bus.mem_rdata_i;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req_o          = r_mem_req;
  assign bus.mem_addr_o         = r_mem_addr;
  assign bus.mem_we_o           = r_mem_we;
  assign bus.mem_wdata_o        = r_mem_wdata;
  assign bus.instr_data_o       = r_instr_data;
  assign bus.data_rdata_o       = r_data_rdata;
  assign bus.instr_blocking_n_o = w_instr_blk_n;
  assign bus.data_blocking_n_o  = w_data_blk_n;

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_core_mem_arbiter
// Description : Scoreboard bench for core_mem_arbiter with a memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_mem_arbiter_if bus ();

  core_mem_arbiter #(.STARVE_LIMIT(4), .TIMEOUT_CYCLES(8)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [29:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    int          cycles;
    bit          stable;
  } txn_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_i_q[$];
  logic [31:0] exp_d_q[$];
  txn_t        txn_q[$];
  int          txn_rd = 0;
  string       order_s = "";
  int          done_i_cnt = 0;
  int          done_d_cnt = 0;
  int          err_cycles = 0;
  int          ack_delay = 0;
  int          spurious_cnt = 0;
  logic [31:0] last_load = 32'h0;

  txn_t        m_t;
  bit          m_in_txn = 1'b0;
  bit          m_acked = 1'b0;
  int          m_spur_seen = 0;

  function automatic logic [31:0] mem_val(input logic [29:0] a);
    if (a == 30'h4) return 32'h00500093;
    return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0000;
  endfunction

  // Memory responder: acks after ack_delay wait cycles and logs each transaction.
  initial begin : mem_model
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = 32'hBAD0_BAD0;
    forever begin
      @(posedge clk); #1;
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = 32'hBAD0_BAD0;
      if (rst) begin
        m_in_txn = 1'b0;
      end else if (bus.mem_req_o) begin
        if (!m_in_txn) begin
          m_in_txn = 1'b1; m_acked = 1'b0;
          m_t.addr = bus.mem_addr_o; m_t.we = bus.mem_we_o; m_t.wdata = bus.mem_wdata_o;
          m_t.cycles = 0; m_t.stable = 1'b1;
        end else if (bus.mem_addr_o !== m_t.addr || bus.mem_we_o !== m_t.we ||
                     bus.mem_wdata_o !== m_t.wdata) begin
          m_t.stable = 1'b0;
        end
        m_t.cycles++;
        if (!m_acked && m_t.cycles == ack_delay + 1) begin
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = mem_val(bus.mem_addr_o);
          m_acked = 1'b1;
        end
      end else begin
        if (m_in_txn) begin
          txn_q.push_back(m_t);
          m_in_txn = 1'b0;
        end
        if (spurious_cnt != m_spur_seen) begin
          m_spur_seen     = spurious_cnt;
          bus.mem_ack_i   = 1'b1;
          bus.mem_rdata_i = 32'hFEED_F00D;
        end
      end
    end
  end

  // Completion monitor: pops the expected read data on every DONE cycle.
  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.mem_err_o === 1'b1) err_cycles++;
        if (bus.instr_req_i === 1'b1 && bus.instr_blocking_n_o === 1'b1) begin
          done_i_cnt++; order_s = {order_s, "I"}; n_checks++;
          if (exp_i_q.size() == 0) begin
            n_errors++;
            $display("FAIL instr_unexpected_done: got data %h, expected no completion", bus.instr_data_o);
          end else begin
            e = exp_i_q.pop_front();
            if (bus.instr_data_o !== e) begin
              n_errors++;
              $display("FAIL instr_data: got %h, expected %h", bus.instr_data_o, e);
            end
          end
        end
        if (bus.data_req_i === 1'b1 && bus.data_blocking_n_o === 1'b1) begin
          done_d_cnt++; order_s = {order_s, "D"}; n_checks++;
          if (exp_d_q.size() == 0) begin
            n_errors++;
            $display("FAIL data_unexpected_done: got data %h, expected no completion", bus.data_rdata_o);
          end else begin
            e = exp_d_q.pop_front();
            if (bus.data_rdata_o !== e) begin
              n_errors++;
              $display("FAIL data_rdata: got %h, expected %h", bus.data_rdata_o, e);
            end
          end
        end
      end
    end
  end

  task automatic issue_i(input logic [29:0] a);
    exp_i_q.push_back(mem_val(a));
    bus.instr_addr_i = a;
    bus.instr_req_i  = 1'b1;
  endtask

  task automatic issue_d(input logic [29:0] a, input logic [3:0] we, input logic [31:0] wd);
    if (we == 4'b0) last_load = mem_val(a);
    exp_d_q.push_back(last_load);
    bus.data_addr_i     = a;
    bus.data_write_en_i = we;
    bus.data_wdata_i    = wd;
    bus.data_req_i      = 1'b1;
  endtask

  // Drops each request on the edge after its DONE cycle, bounded wait.
  task automatic wait_counts(input int ti, input int td);
    bit reached = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      if (done_i_cnt >= ti) bus.instr_req_i = 1'b0;
      if (done_d_cnt >= td) bus.data_req_i  = 1'b0;
      if (done_i_cnt >= ti && done_d_cnt >= td) begin
        reached = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!reached) begin
      n_errors++;
      bus.instr_req_i = 1'b0; bus.data_req_i = 1'b0;
      $display("FAIL completion_wait: got %0d/%0d completions, expected %0d/%0d",
               done_i_cnt, done_d_cnt, ti, td);
    end
    @(posedge clk); #1;
  endtask

  task automatic get_txn(output txn_t t, output bit ok);
    ok = (txn_rd < txn_q.size());
    if (ok) begin
      t = txn_q[txn_rd];
      txn_rd++;
    end else begin
      t = '{addr: '0, we: '0, wdata: '0, cycles: 0, stable: 1'b0};
    end
  endtask

  task automatic test_reset();
    txn_t t; bit ok;
    issue_d(30'h40, 4'b0000, 32'h0);
    repeat (2) @(negedge clk);
    n_checks += 5;
    if (bus.mem_req_o !== 1'b0) begin n_errors++; $display("FAIL rst_mem_req: got %b, expected 0", bus.mem_req_o); end
    if (bus.instr_blocking_n_o !== 1'b1 || bus.data_blocking_n_o !== 1'b1) begin
      n_errors++; $display("FAIL rst_blocking_n: got i=%b d=%b, expected 1/1", bus.instr_blocking_n_o, bus.data_blocking_n_o);
    end
    if ({bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o} !== 66'h0) begin
      n_errors++; $display("FAIL rst_mem_bus: got addr=%h we=%b wdata=%h, expected zeros", bus.mem_addr_o, bus.mem_we_o, bus.mem_wdata_o);
    end
    if (bus.instr_data_o !== 32'h0 || bus.data_rdata_o !== 32'h0) begin
      n_errors++; $display("FAIL rst_read_data: got i=%h d=%h, expected 0/0", bus.instr_data_o, bus.data_rdata_o);
    end
    if (bus.mem_err_o !== 1'b0) begin n_errors++; $display("FAIL rst_mem_err: got %b, expected 0", bus.mem_err_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.data_blocking_n_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin
      n_errors++; $display("FAIL rel_first_cycle: got blk_n=%b req=%b, expected 0/0", bus.data_blocking_n_o, bus.mem_req_o);
    end
    @(negedge clk);
    n_checks++;
    if (bus.mem_req_o !== 1'b1 || bus.mem_addr_o !== 30'h40) begin
      n_errors++; $display("FAIL rel_grant_d: got req=%b addr=%h, expected 1/040", bus.mem_req_o, bus.mem_addr_o);
    end
    wait_counts(done_i_cnt, 1);
    get_txn(t, ok);
    n_checks++;
    if (!ok || t.we !== 4'b0 || t.cycles != 1) begin
      n_errors++; $display("FAIL rst_load_txn: got ok=%b we=%b cycles=%0d, expected 1/0000/1", ok, t.we, t.cycles);
    end
  endtask

  task automatic test_fetch();
    txn_t t; bit ok; bit seen = 1'b0; int stall = 0;
    issue_i(30'h4);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.instr_blocking_n_o === 1'b1) begin seen = 1'b1; break; end
      stall++;
    end
    n_checks++;
    if (!seen || stall != 2) begin
      n_errors++; $display("FAIL fetch_latency: got seen=%b stall=%0d, expected 1/2", seen, stall);
    end
    wait_counts(done_i_cnt + (seen ? 0 : 1), done_d_cnt);
    get_txn(t, ok);
    n_checks++;
    if (!ok || t.addr !== 30'h4 || t.we !== 4'b0 || t.cycles != 1) begin
      n_errors++; $display("FAIL fetch_txn: got ok=%b addr=%h we=%b cycles=%0d, expected 1/004/0000/1", ok, t.addr, t.we, t.cycles);
    end
    n_checks++;
    if (bus.instr_data_o !== 32'h00500093) begin
      n_errors++; $display("FAIL fetch_hold: got %h, expected 00500093", bus.instr_data_o);
    end
  endtask

  task automatic test_store();
    txn_t t; bit ok;
    issue_d(30'h40, 4'b0011, 32'hA5A5_1234);
    wait_counts(done_i_cnt, done_d_cnt + 1);
    get_txn(t, ok);
    n_checks++;
    if (!ok || t.addr !== 30'h40 || t.we !== 4'b0011 || t.wdata !== 32'hA5A5_1234 || !t.stable) begin
      n_errors++; $display("FAIL store_txn: got ok=%b addr=%h we=%b wdata=%h stable=%b, expected 1/040/0011/a5a51234/1",
                           ok, t.addr, t.we, t.wdata, t.stable);
    end
    n_checks++;
    if (bus.data_rdata_o !== mem_val(30'h40)) begin
      n_errors++; $display("FAIL store_rdata_kept: got %h, expected %h", bus.data_rdata_o, mem_val(30'h40));
    end
    issue_d(30'h21, 4'b0000, 32'h0);
    wait_counts(done_i_cnt, done_d_cnt + 1);
    txn_rd = txn_q.size();
    n_checks++;
    if (bus.data_rdata_o !== mem_val(30'h21)) begin
      n_errors++; $display("FAIL load_after_store: got %h, expected %h", bus.data_rdata_o, mem_val(30'h21));
    end
  endtask

  task automatic test_starve();
    int base = order_s.len();
    bit reached = 1'b0;
    string got;
    repeat (8) exp_d_q.push_back(mem_val(30'h80));
    repeat (2) exp_i_q.push_back(mem_val(30'h8));
    last_load = mem_val(30'h80);
    bus.instr_addr_i = 30'h8;
    bus.data_addr_i = 30'h80; bus.data_write_en_i = 4'b0; bus.data_wdata_i = 32'h0;
    bus.instr_req_i = 1'b1; bus.data_req_i = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (order_s.len() >= base + 10) begin reached = 1'b1; break; end
    end
    #1;
    bus.instr_req_i = 1'b0; bus.data_req_i = 1'b0;
    got = reached ? order_s.substr(base, base + 9) : order_s.substr(base, order_s.len() - 1);
    n_checks++;
    if (got != "DDDDIDDDDI") begin
      n_errors++; $display("FAIL starve_order: got %s, expected DDDDIDDDDI", got);
    end
    repeat (3) @(posedge clk); #1;
    txn_rd = txn_q.size();
    n_checks++;
    if (exp_i_q.size() != 0 || exp_d_q.size() != 0) begin
      n_errors++; $display("FAIL starve_leftover: got %0d/%0d pending, expected 0/0", exp_i_q.size(), exp_d_q.size());
    end
  endtask

  task automatic test_ack_delay();
    txn_t t; bit ok;
    int base = order_s.len();
    int bd = done_d_cnt;
    ack_delay = 5;
    issue_d(30'h55, 4'b0000, 32'h0);
    repeat (2) @(posedge clk); #1;
    issue_i(30'h9);
    wait_counts(done_i_cnt + 1, bd + 1);
    n_checks++;
    if (order_s.substr(base, base + 1) != "DI" || done_d_cnt != bd + 1) begin
      n_errors++; $display("FAIL delay_order: got %s with %0d data done, expected DI with 1",
                           order_s.substr(base, order_s.len() - 1), done_d_cnt - bd);
    end
    get_txn(t, ok);
    n_checks++;
    if (!ok || t.addr !== 30'h55 || t.cycles != 6 || !t.stable) begin
      n_errors++; $display("FAIL delay_data_txn: got ok=%b addr=%h cycles=%0d stable=%b, expected 1/055/6/1", ok, t.addr, t.cycles, t.stable);
    end
    get_txn(t, ok);
    n_checks++;
    if (!ok || t.addr !== 30'h9 || t.cycles != 6 || !t.stable) begin
      n_errors++; $display("FAIL delay_instr_txn: got ok=%b addr=%h cycles=%0d stable=%b, expected 1/009/6/1", ok, t.addr, t.cycles, t.stable);
    end
    ack_delay = 0;
  endtask

  task automatic test_spurious_ack();
    spurious_cnt++;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.instr_data_o !== mem_val(30'h9) || bus.data_rdata_o !== last_load || bus.mem_req_o !== 1'b0) begin
      n_errors++; $display("FAIL spurious_ack: got i=%h d=%h req=%b, expected %h/%h/0",
                           bus.instr_data_o, bus.data_rdata_o, bus.mem_req_o, mem_val(30'h9), last_load);
    end
    @(posedge clk); #1;
  endtask

`ifdef CORE_MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    txn_t t; bit ok; bit seen = 1'b0;
    int e0 = err_cycles;
    int bd = done_d_cnt;
    ack_delay = 1000;
    last_load = 32'hdeadbeef;
    exp_d_q.push_back(32'hdeadbeef);
    bus.data_addr_i = 30'h77; bus.data_write_en_i = 4'b0; bus.data_wdata_i = 32'h0;
    bus.data_req_i = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.data_blocking_n_o === 1'b1) begin seen = 1'b1; break; end
    end
    n_checks++;
    if (!seen || bus.mem_err_o !== 1'b1) begin
      n_errors++; $display("FAIL timeout_err_pulse: got seen=%b err=%b, expected 1/1", seen, bus.mem_err_o);
    end
    wait_counts(done_i_cnt, bd + 1);
    get_txn(t, ok);
    n_checks++;
    if (!ok || t.cycles != 8 || err_cycles != e0 + 1) begin
      n_errors++; $display("FAIL timeout_txn: got ok=%b cycles=%0d err_cycles=%0d, expected 1/8/1", ok, t.cycles, err_cycles - e0);
    end
    ack_delay = 0;
  endtask
`endif

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no end of test, expected completion within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int exp_err;
    bus.instr_req_i = 1'b0; bus.instr_addr_i = '0;
    bus.data_req_i = 1'b0; bus.data_addr_i = '0;
    bus.data_write_en_i = '0; bus.data_wdata_i = '0;
    test_reset();
    test_fetch();
    test_store();
    test_starve();
    test_ack_delay();
    test_spurious_ack();
`ifdef CORE_MEM_ARB_TIMEOUT_EN
    test_timeout();
    exp_err = 1;
`else
    exp_err = 0;
`endif
    n_checks++;
    if (err_cycles != exp_err) begin
      n_errors++; $display("FAIL mem_err_total: got %0d cycles, expected %0d", err_cycles, exp_err);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
